// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared types and elaboration helpers for pipelined_shifter
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_e;

    // Radix-4 stages: two count bits per stage, the last stage may take one.
    function automatic int calc_nstage(input int sc_w);
        return (sc_w + 1) / 2;
    endfunction

    function automatic bit is_pow2(input int w);
        return (w >= 4) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// rtl/shifter_stage.sv - one radix-4 shift stage with its register slice; carry tracked when SHIFTER_CARRY_EN is defined
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int SC_W  = $clog2(WIDTH),
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic [1:0]       up_mode,
    input  logic             up_sign,
    input  logic [SC_W-1:0]  up_sc,
    input  logic [TAG_W-1:0] up_tag,
`ifdef SHIFTER_CARRY_EN
    input  logic             up_carry,
    output logic             dn_carry,
`endif
    input  logic             dn_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    output logic [1:0]       dn_mode,
    output logic             dn_sign,
    output logic [SC_W-1:0]  dn_sc,
    output logic [TAG_W-1:0] dn_tag
);

    localparam int LO = 2 * IDX;
    localparam int HI = (2 * IDX + 1 < SC_W) ? 2 * IDX + 1 : SC_W - 1;
    localparam logic [SC_W-1:0]  FIELD_MASK = SC_W'(((1 << (HI + 1)) - 1) - ((1 << LO) - 1));
    localparam logic [SC_W:0]    WIDTH_L    = (SC_W + 1)'(WIDTH);
    localparam logic [WIDTH-1:0] ONES       = '1;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       mode_q, mode_d;
    logic             sign_q, sign_d;
    logic [SC_W-1:0]  sc_rest_q, sc_rest_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             load;
    logic             take;
    logic [SC_W-1:0]  amt;
    logic [SC_W:0]    lsl_idx;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] res;

    // amt is this stage's slice of the count, already weighted by 4^IDX.
    always_comb begin
        amt     = up_sc & FIELD_MASK;
        lsl_idx = WIDTH_L - {1'b0, amt};
        shr     = up_data >> amt;
        fill    = up_sign ? ~(ONES >> amt) : '0;
        case (shift_mode_e'(up_mode))
            SH_LSL:  res = up_data << amt;
            SH_LSR:  res = shr;
            SH_ASR:  res = shr | fill;
            default: res = shr | (up_data << lsl_idx);
        endcase
    end

    always_comb begin
        load      = ~valid_q | dn_ready;
        take      = load & up_valid;
        valid_d   = flush ? 1'b0 : (load ? up_valid : valid_q);
        data_d    = take ? res : data_q;
        mode_d    = take ? up_mode : mode_q;
        sign_d    = take ? up_sign : sign_q;
        sc_rest_d = take ? up_sc : sc_rest_q;
        tag_d     = take ? up_tag : tag_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            mode_q    <= '0;
            sign_q    <= 1'b0;
            sc_rest_q <= '0;
            tag_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            sign_q    <= sign_d;
            sc_rest_q <= sc_rest_d;
            tag_q     <= tag_d;
        end
    end

`ifdef SHIFTER_CARRY_EN
    logic            carry_q, carry_d;
    logic [SC_W-1:0] rsh_idx;
    logic            cout;

    // A zero-shift stage passes the upstream carry through untouched.
    always_comb begin
        rsh_idx = amt - SC_W'(1);
        cout    = up_carry;
        if (amt != '0) begin
            case (shift_mode_e'(up_mode))
                SH_LSL:         cout = up_data[lsl_idx[SC_W-1:0]];
                SH_LSR, SH_ASR: cout = up_data[rsh_idx];
                default:        cout = res[WIDTH-1];
            endcase
        end
        carry_d = take ? cout : carry_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign dn_carry = carry_q;
`endif

    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign dn_mode  = mode_q;
    assign dn_sign  = sign_q;
    assign dn_sc    = sc_rest_q;
    assign dn_tag   = tag_q;

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - radix-4 pipelined LSL/LSR/ASR/ROR unit with valid/ready; out_c exists only with SHIFTER_CARRY_EN
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 4,
    parameter int SC_W   = $clog2(WIDTH),
    parameter int NSTAGE = calc_nstage(SC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [SC_W-1:0]  in_sc,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [TAG_W-1:0] out_tag
`ifdef SHIFTER_CARRY_EN
    ,
    output logic             out_c
`endif
);

    if (!is_pow2(WIDTH)) begin : g_width_check
        $error("pipelined_shifter: WIDTH must be a power of two and at least 4");
    end

    // Index 0 is the input port side; index i+1 is the output of stage i.
    logic [NSTAGE:0]             vld_w;
    logic [NSTAGE:0][WIDTH-1:0]  data_w;
    logic [NSTAGE:0][1:0]        mode_w;
    logic [NSTAGE:0]             sign_w;
    logic [NSTAGE:0][SC_W-1:0]   sc_pipe;
    logic [NSTAGE:0][TAG_W-1:0]  tag_w;
    logic [NSTAGE:0]             rdy;

    assign vld_w[0]   = in_valid;
    assign data_w[0]  = in_x;
    assign mode_w[0]  = in_mode;
    assign sign_w[0]  = in_x[WIDTH-1];
    assign sc_pipe[0] = in_sc;
    assign tag_w[0]   = in_tag;

`ifdef SHIFTER_CARRY_EN
    logic [NSTAGE:0] carry_w;
    assign carry_w[0] = 1'b0;
`endif

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .SC_W  (SC_W),
            .IDX   (i)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .up_valid (vld_w[i]),
            .up_data  (data_w[i]),
            .up_mode  (mode_w[i]),
            .up_sign  (sign_w[i]),
            .up_sc    (sc_pipe[i]),
            .up_tag   (tag_w[i]),
`ifdef SHIFTER_CARRY_EN
            .up_carry (carry_w[i]),
            .dn_carry (carry_w[i+1]),
`endif
            .dn_ready (rdy[i+1]),
            .dn_valid (vld_w[i+1]),
            .dn_data  (data_w[i+1]),
            .dn_mode  (mode_w[i+1]),
            .dn_sign  (sign_w[i+1]),
            .dn_sc    (sc_pipe[i+1]),
            .dn_tag   (tag_w[i+1])
        );
    end

    // rdy[i]: stage i can take a new entry this cycle (empty, or its occupant moves on).
    always_comb begin
        rdy         = '0;
        rdy[NSTAGE] = out_ready;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            rdy[i] = ~vld_w[i+1] | rdy[i+1];
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld_w[NSTAGE];
    assign out_y     = data_w[NSTAGE];
    assign out_tag   = tag_w[NSTAGE];

`ifdef SHIFTER_CARRY_EN
    assign out_c = carry_w[NSTAGE];
`endif

    logic unused_tail;
    assign unused_tail = ^{mode_w[NSTAGE], sign_w[NSTAGE], sc_pipe[NSTAGE]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - directed self-checking bench for pipelined_shifter (WIDTH=32, TAG_W=4), out_c checked when SHIFTER_CARRY_EN is defined
module tb_pipelined_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [4:0]  in_sc;
    logic [1:0]  in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_tag;
`ifdef SHIFTER_CARRY_EN
    logic        out_c;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipelined_shifter #(.WIDTH(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_sc     (in_sc),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag)
`ifdef SHIFTER_CARRY_EN
        ,
        .out_c     (out_c)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string name, input logic [31:0] x, input logic [4:0] sc,
                           input logic [1:0] mode, input logic [3:0] tag,
                           input logic [31:0] exp_y, input logic exp_c);
        int cnt;
        in_valid  = 1'b1;
        in_x      = x;
        in_sc     = sc;
        in_mode   = mode;
        in_tag    = tag;
        out_ready = 1'b1;
        #1;
        check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check({name, " latency"}, cnt, 32'd3);
        check({name, " y"}, out_y, exp_y);
        check({name, " tag"}, {28'b0, out_tag}, {28'b0, tag});
`ifdef SHIFTER_CARRY_EN
        check({name, " c"}, {31'b0, out_c}, {31'b0, exp_c});
`else
        if (exp_c === 1'bx) $error("FAIL %s: bad expected carry", name);
`endif
        tick();
    endtask

    initial begin
        int          sent;
        int          recv;
        int          inflight;
        int          maxfl;
        int          seen;
        bit          stalled;
        logic [31:0] stall_y;
        logic [3:0]  stall_tag;
        logic [31:0] exp_y;

        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_sc     = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        #12;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_y", out_y, 32'h0);
        check("reset out_tag", {28'b0, out_tag}, 32'h0);
`ifdef SHIFTER_CARRY_EN
        check("reset out_c", {31'b0, out_c}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        tick();

        run_one("lsl31",   32'h0000_0001, 5'd31, 2'b00, 4'd5, 32'h8000_0000, 1'b0);
        run_one("asr4",    32'h8000_0000, 5'd4,  2'b10, 4'd1, 32'hF800_0000, 1'b0);
        run_one("lsr4",    32'h8000_0000, 5'd4,  2'b01, 4'd2, 32'h0800_0000, 1'b0);
        run_one("lsl1c",   32'h8000_0001, 5'd1,  2'b00, 4'd3, 32'h0000_0002, 1'b1);
        run_one("ror8",    32'h1234_5678, 5'd8,  2'b11, 4'd4, 32'h7812_3456, 1'b0);
        run_one("lsl0",    32'hDEAD_BEEF, 5'd0,  2'b00, 4'd6, 32'hDEAD_BEEF, 1'b0);
        run_one("lsr0",    32'hDEAD_BEEF, 5'd0,  2'b01, 4'd7, 32'hDEAD_BEEF, 1'b0);
        run_one("asr0",    32'hDEAD_BEEF, 5'd0,  2'b10, 4'd8, 32'hDEAD_BEEF, 1'b0);
        run_one("ror0",    32'hDEAD_BEEF, 5'd0,  2'b11, 4'd9, 32'hDEAD_BEEF, 1'b0);
        run_one("asr31",   32'h8000_0000, 5'd31, 2'b10, 4'hA, 32'hFFFF_FFFF, 1'b0);
        run_one("asr29p",  32'h7000_0000, 5'd29, 2'b10, 4'hB, 32'h0000_0003, 1'b1);
        run_one("ror1",    32'h0000_0001, 5'd1,  2'b11, 4'hC, 32'h8000_0000, 1'b1);
        run_one("lsr5",    32'h0000_00F0, 5'd5,  2'b01, 4'hD, 32'h0000_0007, 1'b1);
        run_one("lsl17",   32'h0001_8001, 5'd17, 2'b00, 4'hE, 32'h0002_0000, 1'b1);

        // Back-to-back tags 0..7 with out_ready low in cycles 4..9.
        sent = 0;
        recv = 0;
        maxfl = 0;
        stalled = 1'b0;
        stall_y = '0;
        stall_tag = '0;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            in_valid  = (sent < 8);
            in_x      = 32'h100 + 32'(sent);
            in_sc     = 5'(sent);
            in_mode   = 2'b00;
            in_tag    = 4'(sent);
            out_ready = !(c >= 4 && c <= 9);
            @(negedge clk);
            inflight = sent - recv;
            if (inflight > maxfl) maxfl = inflight;
            if (inflight == 3 && !out_ready)
                check("bp in_ready full", {31'b0, in_ready}, 32'd0);
            if (out_valid && !out_ready) begin
                if (stalled) begin
                    check("bp stable y", out_y, stall_y);
                    check("bp stable tag", {28'b0, out_tag}, {28'b0, stall_tag});
                end
                stall_y   = out_y;
                stall_tag = out_tag;
                stalled   = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                exp_y = (32'h100 + 32'(recv)) << recv;
                check("bp tag order", {28'b0, out_tag}, 32'(recv));
                check("bp y", out_y, exp_y);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp sent", 32'(sent), 32'd8);
        check("bp recv", 32'(recv), 32'd8);
        check("bp max held", 32'(maxfl), 32'd3);
        tick();
        check("bp drained", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset with three ops in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_x     = 32'h5555_0000 + 32'(k);
            in_sc    = 5'd3;
            in_mode  = 2'b01;
            in_tag   = 4'(k + 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst out_y", out_y, 32'h0);
        check("async rst out_tag", {28'b0, out_tag}, 32'h0);
        check("async rst in_ready", {31'b0, in_ready}, 32'd1);
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        run_one("post-rst", 32'h0000_00FF, 5'd4, 2'b00, 4'h6, 32'h0000_0FF0, 1'b0);
        seen = 0;
        repeat (5) begin
            if (out_valid) seen++;
            tick();
        end
        check("post-rst no stale", 32'(seen), 32'd0);

        // Flush with two ops in flight and a third offered in the flush cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_x     = 32'hA5A5_0000 + 32'(k);
            in_sc    = 5'd2;
            in_mode  = 2'b00;
            in_tag   = 4'(k + 10);
            tick();
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 4'hF;
        #1;
        check("flush in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        repeat (6) begin
            if (out_valid) seen++;
            tick();
        end
        check("flush no output", 32'(seen), 32'd0);
        run_one("post-flush", 32'h8765_4321, 5'd16, 2'b11, 4'h2, 32'h4321_8765, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the combinational LSL shifter.
- Executes LSL, LSR, ASR and ROR on a WIDTH-bit operand using radix-4 stages: each stage consumes 2 shift-count bits, and the last stage may consume 1.
- Each stage is followed by a register, with valid/ready flow control.
- Sits between operand fetch and the register-file writeback in the RISC5 execute path. It can also serve as a standalone shift unit for peripherals.

Parameters:
- WIDTH, 32: operand width. Must be a power of two, at least 4.
- TAG_W, 4: width of the opaque tag carried alongside each operation.
- SC_W, $clog2(WIDTH): shift-count width. Derived; do not override.
- NSTAGE, (SC_W+1)/2: number of pipeline stages, equal to the latency. Derived.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; clears all in-flight operations.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid & in_ready.
- in_x  in  WIDTH  operand.
- in_sc  in  SC_W  shift count.
- in_mode  in  2  shift mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_c  out  1  carry out. Present only with SHIFTER_CARRY_EN.

Behaviour:
- Stage ordering: stage i shifts by sc[2i+1:2i] × 4^i. For WIDTH=32:
  - stage 0 uses sc[1:0] (shift 0–3);
  - stage 1 uses sc[3:2] (shift 0/4/8/12);
  - stage 2 uses sc[4] (shift 0/16).
- Fill rules:
  - LSL: zero-fills the LSBs.
  - LSR: zero-fills the MSBs.
  - ASR: fills with the operand's original bit WIDTH-1. The sign is carried down the pipeline, not re-read from the partial result.
  - ROR: rotates right.
  - The mode is registered with the data at every stage.
- Registers: each stage has valid_q, data_q, mode_q, sign_q, sc_rest_q and tag_q.
- Flow control (no bubbles): stage i loads when valid_q[i]==0 or stage i+1 accepts. The last stage's downstream accept is out_ready.
  - in_ready = ~valid_q[0] | ready_into_stage1.
  - Throughput: 1 op/cycle when out_ready is held high.
- Latency: NSTAGE cycles from the accepting edge to out_valid=1 (3 cycles at WIDTH=32). out_* come directly from the last stage's registers.
- Ordering and stability:
  - Results leave in acceptance order.
  - While out_valid & ~out_ready, out_y, out_tag and out_c hold stable.
  - A full pipeline under sustained backpressure holds NSTAGE ops, then in_ready=0.
- Reset (rst=0): asynchronously clears every valid_q. Data registers also go to 0. Outputs become out_valid=0, out_y=0, out_tag=0, out_c=0, in_ready=1 while reset is held. Any in-flight ops are lost.
- flush=1: at the next edge clears every valid_q; data content is don't-care. An in_valid presented in the same cycle is not accepted: in_ready=0 while flush=1.
- Count and width edge cases:
  - sc=0: y=x in every mode.
  - No count exceeds WIDTH-1, since in_sc is only SC_W bits wide.
- A simultaneous output drain and input accept on a full pipeline is legal, and all stages advance.

Optional Feature:
- Macro: SHIFTER_CARRY_EN.
- When defined:
  - Port out_c is present.
  - out_c is 0 when sc=0, for every mode.
  - Otherwise out_c is the last bit shifted out:
    - LSL: x[WIDTH-sc];
    - LSR/ASR: x[sc-1];
    - ROR: y[WIDTH-1].
  - Carry is tracked per stage and registered alongside the data: a stage with a nonzero shift overwrites the carry, a stage with a zero shift keeps it.
- When undefined: port out_c and the carry registers are absent. All other behaviour is identical.

Decomposition:
- Package shifter_pkg holds:
  - the mode typedef (2-bit enum: SH_LSL, SH_LSR, SH_ASR, SH_ROR);
  - the NSTAGE derivation function;
  - a static check that WIDTH is a power of two.
- One sub-module, shifter_stage: a single radix-4 stage with its register and local valid/ready. It is parameterised by stage index and WIDTH, and instantiated NSTAGE times in a generate loop.

Test Plan (WIDTH=32, TAG_W=4):
- LSL, x=0x0000_0001, sc=31, tag=5 → out_y=0x8000_0000, out_tag=5, out_valid exactly 3 cycles after accept.
- x=0x8000_0000, sc=4: ASR → 0xF800_0000; LSR → 0x0800_0000. With SHIFTER_CARRY_EN: LSL x=0x8000_0001, sc=1 → y=0x0000_0002, out_c=1.
- ROR, x=0x1234_5678, sc=8 → 0x7812_3456. Then all four modes with sc=0 and x=0xDEAD_BEEF → y=0xDEAD_BEEF, out_c=0.
- Back-to-back ops with tags 0..7, out_ready held low for cycles 4–9:
  - in_ready drops once 3 ops are held;
  - no loss, no duplication;
  - tags emerge in order 0..7;
  - out_y stays stable while stalled.
- rst pulled low asynchronously mid-clock with 3 ops in flight → out_valid falls immediately without waiting for an edge. After release, a new op appears after 3 cycles with no stale data.
- flush asserted for one cycle with 2 ops in flight and in_valid=1 → that cycle's op is not accepted (in_ready=0), and neither in-flight op ever appears on out_valid.
